// File: rtl/accel_loader_pkg.sv
// accel_loader_pkg: shared types and constants for the accelerator host loader.
//   - cmd_e      : header command codes
//   - state_e    : loader FSM states
//   - HDR_*      : bit positions of the header word fields
//   - STATUS_TAG : upper half of the RUN completion status word
//   - sat_inc16  : saturating 16-bit increment used by the run cycle counter
package accel_loader_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [3:0] {
        CMD_LOAD_I = 4'd1,
        CMD_LOAD_D = 4'd2,
        CMD_RUN    = 4'd3,
        CMD_READ_D = 4'd4
    } cmd_e;

    typedef enum logic [2:0] {
        StIdle,
        StLoadI,
        StLoadD,
        StRunWait,
        StReadIssue,
        StReadSend
    } state_e;

    // Header word layout: [31:28] cmd, [20:16] base address, [7:0] count.
    localparam int unsigned HDR_CMD_MSB  = 31;
    localparam int unsigned HDR_CMD_LSB  = 28;
    localparam int unsigned HDR_ADDR_MSB = 20;
    localparam int unsigned HDR_ADDR_LSB = 16;
    localparam int unsigned HDR_CNT_MSB  = 7;
    localparam int unsigned HDR_CNT_LSB  = 0;

    localparam logic [15:0] STATUS_TAG = 16'hD0E0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/accel_loader_out_reg.sv
// accel_loader_out_reg: single-entry output register with valid/ready hold.
// Carries both readback words and the RUN status word to the host.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : load push_data and raise out_valid (only issued while empty)
//   push_data   : word to present
//   out_valid   : word held on out_data
//   out_ready   : host accepts the word; out_valid drops on that edge
//   out_data    : held word, stable until accepted
module accel_loader_out_reg
    import accel_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data
);

    logic              valid_q;
    logic [WORD_W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (push) begin
            valid_q <= 1'b1;
            data_q  <= push_data;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/accel_host_loader.sv
// accel_host_loader: converts a 32-bit host word stream into instruction-store and
// data-memory writes, launches the core, waits for HALT and streams data memory back.
// Optional feature macro: ACCEL_LOADER_CHECKSUM_EN (trailing XOR word on loads and reads).
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data       : host word stream (headers and payload)
//   out_valid/out_ready/out_data    : readback and status words to the host
//   instr_we/instr_addr/instr_wdata : instruction store write port
//   mem_we/mem_addr/mem_wdata       : data memory write port (mem_addr also reads)
//   mem_rdata                       : data memory read value, 1 cycle after mem_addr
//   core_start                      : one-cycle pulse releasing the core from PC 0
//   core_halted                     : core has executed HALT
//   err                             : sticky protocol error
module accel_host_loader
    import accel_loader_pkg::*;
#(
    parameter int NUM_SIZE         = 16,
    parameter int NUM_INSTRUCTIONS = 16,
    parameter int WORDS_IN_MEMORY  = 32,
    parameter int IADDR_W          = $clog2(NUM_INSTRUCTIONS),
    parameter int DADDR_W          = $clog2(WORDS_IN_MEMORY)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_data,
    output logic                instr_we,
    output logic [IADDR_W-1:0]  instr_addr,
    output logic [31:0]         instr_wdata,
    output logic                mem_we,
    output logic [DADDR_W-1:0]  mem_addr,
    output logic [NUM_SIZE-1:0] mem_wdata,
    input  logic [NUM_SIZE-1:0] mem_rdata,
    output logic                core_start,
    input  logic                core_halted,
    output logic                err
);

    localparam int PTR_W = (IADDR_W > DADDR_W) ? IADDR_W : DADDR_W;

    logic [3:0] hdr_cmd;
    logic [4:0] hdr_base;
    logic [7:0] hdr_count;

    assign hdr_cmd   = in_data[HDR_CMD_MSB:HDR_CMD_LSB];
    assign hdr_base  = in_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
    assign hdr_count = in_data[HDR_CNT_MSB:HDR_CNT_LSB];

    state_e               state_q, state_d;
    logic [7:0]           count_q, count_d;
    logic [8:0]           idx_q, idx_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic                 in_ready_q, in_ready_d;
    logic                 instr_we_q, instr_we_d;
    logic [IADDR_W-1:0]   instr_addr_q, instr_addr_d;
    logic                 mem_we_q, mem_we_d;
    logic [DADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 core_start_q, core_start_d;
    logic [15:0]          cyc_q, cyc_d;
    logic                 err_q, err_d;

    logic                 push;
    logic [31:0]          push_data;
    logic                 in_acc;
    logic                 is_last;
    logic                 is_trailer;

`ifdef ACCEL_LOADER_CHECKSUM_EN
    logic [31:0]          xor_q, xor_d;
    logic                 trailer_q, trailer_d;
    // Payload occupies idx 0..count-1; the word at idx == count is the checksum.
    assign is_trailer = (idx_q == {1'b0, count_q});
`else
    assign is_trailer = 1'b0;
`endif

    // in_ready is registered so it reads 0 while reset is asserted.
    assign in_acc  = in_valid && in_ready_q;
    assign is_last = (idx_q == ({1'b0, count_q} - 9'd1));

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        idx_d        = idx_q;
        ptr_d        = ptr_q;
        instr_we_d   = 1'b0;
        instr_addr_d = instr_addr_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        wdata_d      = wdata_q;
        core_start_d = 1'b0;
        cyc_d        = cyc_q;
        err_d        = err_q;
        push         = 1'b0;
        push_data    = '0;
`ifdef ACCEL_LOADER_CHECKSUM_EN
        xor_d        = xor_q;
        trailer_d    = trailer_q;
`endif

        case (state_q)
            StIdle: begin
                if (in_acc) begin
                    count_d = hdr_count;
                    idx_d   = '0;
                    ptr_d   = PTR_W'(hdr_base);
`ifdef ACCEL_LOADER_CHECKSUM_EN
                    xor_d     = '0;
                    trailer_d = 1'b0;
`endif
                    case (hdr_cmd)
                        CMD_LOAD_I: if (hdr_count != 8'd0) state_d = StLoadI;
                        CMD_LOAD_D: if (hdr_count != 8'd0) state_d = StLoadD;
                        CMD_RUN: begin
                            core_start_d = 1'b1;
                            cyc_d        = '0;
                            state_d      = StRunWait;
                        end
                        CMD_READ_D: begin
                            if (hdr_count != 8'd0) begin
                                mem_addr_d = DADDR_W'(hdr_base);
                                state_d    = StReadIssue;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end

            StLoadI, StLoadD: begin
                if (in_acc) begin
                    if (is_trailer) begin
`ifdef ACCEL_LOADER_CHECKSUM_EN
                        if (in_data != xor_q) err_d = 1'b1;
`endif
                        state_d = StIdle;
                    end else begin
                        if (state_q == StLoadI) begin
                            instr_we_d   = 1'b1;
                            instr_addr_d = ptr_q[IADDR_W-1:0];
                        end else begin
                            mem_we_d   = 1'b1;
                            mem_addr_d = ptr_q[DADDR_W-1:0];
                        end
                        wdata_d = in_data;
                        ptr_d   = ptr_q + PTR_W'(1);
                        idx_d   = idx_q + 9'd1;
`ifdef ACCEL_LOADER_CHECKSUM_EN
                        xor_d = xor_q ^ in_data;
`else
                        if (is_last) state_d = StIdle;
`endif
                    end
                end
            end

            StRunWait: begin
                if (out_valid) begin
                    if (out_ready) state_d = StIdle;
                end else begin
                    // cyc_q is 0 in the start-pulse cycle, so halt is honoured from 2 on.
                    cyc_d = sat_inc16(cyc_q);
                    if (core_halted && (cyc_q >= 16'd2)) begin
                        push      = 1'b1;
                        push_data = {STATUS_TAG, cyc_q};
                    end
                end
            end

            // mem_addr is presented here; mem_rdata is valid in StReadSend.
            StReadIssue: state_d = StReadSend;

            StReadSend: begin
                if (!out_valid) begin
                    push = 1'b1;
`ifdef ACCEL_LOADER_CHECKSUM_EN
                    if (trailer_q) begin
                        push_data = xor_q;
                    end else begin
                        push_data = 32'(mem_rdata);
                        xor_d     = xor_q ^ 32'(mem_rdata);
                    end
`else
                    push_data = 32'(mem_rdata);
`endif
                end else if (out_ready) begin
                    // Advance only on acceptance so back-pressure never drops a word.
                    idx_d      = idx_q + 9'd1;
                    mem_addr_d = mem_addr_q + DADDR_W'(1);
                    state_d    = StReadIssue;
`ifdef ACCEL_LOADER_CHECKSUM_EN
                    if (trailer_q) state_d = StIdle;
                    else if (is_last) trailer_d = 1'b1;
`else
                    if (is_last) state_d = StIdle;
`endif
                end
            end

            default: state_d = StIdle;
        endcase

        in_ready_d = (state_d == StIdle) || (state_d == StLoadI) || (state_d == StLoadD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            count_q      <= '0;
            idx_q        <= '0;
            ptr_q        <= '0;
            in_ready_q   <= 1'b0;
            instr_we_q   <= 1'b0;
            instr_addr_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            wdata_q      <= '0;
            core_start_q <= 1'b0;
            cyc_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            ptr_q        <= ptr_d;
            in_ready_q   <= in_ready_d;
            instr_we_q   <= instr_we_d;
            instr_addr_q <= instr_addr_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            wdata_q      <= wdata_d;
            core_start_q <= core_start_d;
            cyc_q        <= cyc_d;
            err_q        <= err_d;
        end
    end

`ifdef ACCEL_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_q     <= '0;
            trailer_q <= 1'b0;
        end else begin
            xor_q     <= xor_d;
            trailer_q <= trailer_d;
        end
    end
`endif

    accel_loader_out_reg u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign in_ready    = in_ready_q;
    assign instr_we    = instr_we_q;
    assign instr_addr  = instr_addr_q;
    assign instr_wdata = wdata_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = wdata_q[NUM_SIZE-1:0];
    assign core_start  = core_start_q;
    assign err         = err_q;

endmodule
